// File: rtl/rv32_pkg.sv
// Shared types and constants for the RV32I execute stage: ALU op codes,
// forwarding/operand selects and the EX/MEM pipeline register layout.
package rv32_pkg;

   localparam int XLEN      = 32;
   localparam int REGADDR_W = 5;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_AND  = 4'b0010,
      ALU_OR   = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SLL  = 4'b0101,
      ALU_SRL  = 4'b0110,
      ALU_SLT  = 4'b0111,
      ALU_SLTU = 4'b1000,
      ALU_SRA  = 4'b1001,
      ALU_LINK = 4'b1111
   } alu_op_e;

   typedef enum logic [1:0] {
      FWD_IDEX = 2'd0,
      FWD_EXM  = 2'd1,
      FWD_WB   = 2'd2,
      FWD_RSVD = 2'd3
   } fwd_sel_e;

   typedef enum logic [1:0] {
      A_RS1  = 2'd0,
      A_PC   = 2'd1,
      A_ZERO = 2'd2,
      A_RSVD = 2'd3
   } a_sel_e;

   typedef struct packed {
      logic                 valid;
      logic [XLEN-1:0]      result;
      logic [XLEN-1:0]      store;
      logic [REGADDR_W-1:0] rd;
      logic [2:0]           func3;
      logic                 reg_write;
      logic                 mem_read;
      logic                 mem_write;
   } exmem_t;

endpackage

// File: rtl/rv32_alu.sv
// Combinational RV32I ALU. Shifts use b[4:0]; unlisted op codes yield zero.
module rv32_alu
   import rv32_pkg::*;
(
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] result
);

   logic [4:0] shamt;
   assign shamt = b[4:0];

   always_comb begin
      result = '0;
      case (op)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         ALU_SLL:  result = a << shamt;
         ALU_SRL:  result = a >> shamt;
         ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
         ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
         ALU_LINK: result = pc + XLEN'(4);
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, operand selection, ALU and the
// EX/MEM pipeline register with stall/flush control.
module ex_stage
   import rv32_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall_i,
   input  logic                 flush_i,
   input  logic                 id_valid_i,
   input  logic [3:0]           alu_sel_i,
   input  logic [1:0]           a_sel_i,
   input  logic                 b_imm_i,
   input  logic [1:0]           fwd_a_i,
   input  logic [1:0]           fwd_b_i,
   input  logic [XLEN-1:0]      rs1_data_i,
   input  logic [XLEN-1:0]      rs2_data_i,
   input  logic [XLEN-1:0]      imm_i,
   input  logic [XLEN-1:0]      pc_i,
   input  logic [XLEN-1:0]      wb_data_i,
   input  logic [REGADDR_W-1:0] rd_i,
   input  logic [2:0]           func3_i,
   input  logic                 reg_write_i,
   input  logic                 mem_read_i,
   input  logic                 mem_write_i,
   output logic                 exm_valid_o,
   output logic [XLEN-1:0]      exm_result_o,
   output logic [XLEN-1:0]      exm_store_o,
   output logic [REGADDR_W-1:0] exm_rd_o,
   output logic [2:0]           exm_func3_o,
   output logic                 exm_reg_write_o,
   output logic                 exm_mem_read_o,
   output logic                 exm_mem_write_o
);

   exmem_t          exm_q;
   exmem_t          exm_d;
   logic [XLEN-1:0] rs1_fwd;
   logic [XLEN-1:0] rs2_fwd;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] alu_result;

   // Forward code 1 feeds back our own registered result (back-to-back use).
   always_comb begin
      rs1_fwd = rs1_data_i;
      case (fwd_a_i)
         FWD_EXM: rs1_fwd = exm_q.result;
         FWD_WB:  rs1_fwd = wb_data_i;
         default: rs1_fwd = rs1_data_i;
      endcase
   end

   always_comb begin
      rs2_fwd = rs2_data_i;
      case (fwd_b_i)
         FWD_EXM: rs2_fwd = exm_q.result;
         FWD_WB:  rs2_fwd = wb_data_i;
         default: rs2_fwd = rs2_data_i;
      endcase
   end

   always_comb begin
      op_a = '0;
      case (a_sel_i)
         A_RS1:   op_a = rs1_fwd;
         A_PC:    op_a = pc_i;
         default: op_a = '0;
      endcase
   end

   assign op_b = b_imm_i ? imm_i : rs2_fwd;

   rv32_alu u_alu (
      .op     (alu_sel_i),
      .a      (op_a),
      .b      (op_b),
      .pc     (pc_i),
      .result (alu_result)
   );

   always_comb begin
      exm_d           = '0;
      exm_d.valid     = id_valid_i;
      exm_d.result    = alu_result;
      exm_d.store     = rs2_fwd;
      exm_d.rd        = rd_i;
      exm_d.func3     = func3_i;
      exm_d.reg_write = reg_write_i & id_valid_i;
      exm_d.mem_read  = mem_read_i  & id_valid_i;
      exm_d.mem_write = mem_write_i & id_valid_i;
   end

   // Stall outranks flush: a held instruction must not be squashed while
   // downstream is not ready. Flush kills only valid/control, data is held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exm_q <= '0;
      end else if (stall_i) begin
         exm_q <= exm_q;
      end else if (flush_i) begin
         exm_q.valid     <= 1'b0;
         exm_q.reg_write <= 1'b0;
         exm_q.mem_read  <= 1'b0;
         exm_q.mem_write <= 1'b0;
      end else begin
         exm_q <= exm_d;
      end
   end

   assign exm_valid_o     = exm_q.valid;
   assign exm_result_o    = exm_q.result;
   assign exm_store_o     = exm_q.store;
   assign exm_rd_o        = exm_q.rd;
   assign exm_func3_o     = exm_q.func3;
   assign exm_reg_write_o = exm_q.reg_write;
   assign exm_mem_read_o  = exm_q.mem_read;
   assign exm_mem_write_o = exm_q.mem_write;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: hand-computed vectors checked with immediate
// assertions one cycle after each issuing edge.
module tb_ex_stage;
   import rv32_pkg::*;

   logic                 clk;
   logic                 rst;
   logic                 stall_i;
   logic                 flush_i;
   logic                 id_valid_i;
   logic [3:0]           alu_sel_i;
   logic [1:0]           a_sel_i;
   logic                 b_imm_i;
   logic [1:0]           fwd_a_i;
   logic [1:0]           fwd_b_i;
   logic [XLEN-1:0]      rs1_data_i;
   logic [XLEN-1:0]      rs2_data_i;
   logic [XLEN-1:0]      imm_i;
   logic [XLEN-1:0]      pc_i;
   logic [XLEN-1:0]      wb_data_i;
   logic [REGADDR_W-1:0] rd_i;
   logic [2:0]           func3_i;
   logic                 reg_write_i;
   logic                 mem_read_i;
   logic                 mem_write_i;
   logic                 exm_valid_o;
   logic [XLEN-1:0]      exm_result_o;
   logic [XLEN-1:0]      exm_store_o;
   logic [REGADDR_W-1:0] exm_rd_o;
   logic [2:0]           exm_func3_o;
   logic                 exm_reg_write_o;
   logic                 exm_mem_read_o;
   logic                 exm_mem_write_o;

   int n_checks = 0;
   int n_errors = 0;

   ex_stage dut (
      .clk             (clk),
      .rst             (rst),
      .stall_i         (stall_i),
      .flush_i         (flush_i),
      .id_valid_i      (id_valid_i),
      .alu_sel_i       (alu_sel_i),
      .a_sel_i         (a_sel_i),
      .b_imm_i         (b_imm_i),
      .fwd_a_i         (fwd_a_i),
      .fwd_b_i         (fwd_b_i),
      .rs1_data_i      (rs1_data_i),
      .rs2_data_i      (rs2_data_i),
      .imm_i           (imm_i),
      .pc_i            (pc_i),
      .wb_data_i       (wb_data_i),
      .rd_i            (rd_i),
      .func3_i         (func3_i),
      .reg_write_i     (reg_write_i),
      .mem_read_i      (mem_read_i),
      .mem_write_i     (mem_write_i),
      .exm_valid_o     (exm_valid_o),
      .exm_result_o    (exm_result_o),
      .exm_store_o     (exm_store_o),
      .exm_rd_o        (exm_rd_o),
      .exm_func3_o     (exm_func3_o),
      .exm_reg_write_o (exm_reg_write_o),
      .exm_mem_read_o  (exm_mem_read_o),
      .exm_mem_write_o (exm_mem_write_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".valid"},  32'(exm_valid_o), 32'd0);
      check({tag, ".result"}, exm_result_o, 32'd0);
      check({tag, ".store"},  exm_store_o, 32'd0);
      check({tag, ".rd"},     32'(exm_rd_o), 32'd0);
      check({tag, ".func3"},  32'(exm_func3_o), 32'd0);
      check({tag, ".ctrl"},   32'({exm_reg_write_o, exm_mem_read_o, exm_mem_write_o}), 32'd0);
   endtask

   // One edge, then sample 1 ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [1:0] asel, input logic bimm,
                        input logic [1:0] fa, input logic [1:0] fb,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm, input logic [31:0] pc);
      id_valid_i  = 1'b1;
      alu_sel_i   = op;
      a_sel_i     = asel;
      b_imm_i     = bimm;
      fwd_a_i     = fa;
      fwd_b_i     = fb;
      rs1_data_i  = rs1;
      rs2_data_i  = rs2;
      imm_i       = imm;
      pc_i        = pc;
      rd_i        = 5'd1;
      func3_i     = 3'd0;
      reg_write_i = 1'b1;
      mem_read_i  = 1'b0;
      mem_write_i = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      stall_i   = 1'b0;
      flush_i   = 1'b0;
      wb_data_i = 32'd0;
      issue(ALU_ADD, A_RS1, 1'b0, FWD_IDEX, FWD_IDEX, 32'd1, 32'd2, 32'd0, 32'd0);
      #2;
      check_all_zero("reset_initial");
      #10;
      rst = 1'b0;

      // Traffic, then async reset between edges.
      step();
      check("pre_reset_add", exm_result_o, 32'd3);
      #1 rst = 1'b1;
      #1 check_all_zero("reset_async");
      #1 rst = 1'b0;
      issue(ALU_ADD, A_RS1, 1'b0, FWD_IDEX, FWD_IDEX, 32'd5, 32'd7, 32'd0, 32'd0);
      step();
      check("post_reset_add", exm_result_o, 32'd12);
      check("post_reset_valid", 32'(exm_valid_o), 32'd1);
      check("post_reset_regw", 32'(exm_reg_write_o), 32'd1);

      // ALU sweep
      issue(ALU_SUB, A_RS1, 1'b0, FWD_IDEX, FWD_IDEX, 32'h8000_0000, 32'd1, 32'd0, 32'd0);
      step(); check("sub", exm_result_o, 32'h7FFF_FFFF);
      issue(ALU_SLT, A_RS1, 1'b0, FWD_IDEX, FWD_IDEX, 32'h8000_0000, 32'd1, 32'd0, 32'd0);
      step(); check("slt", exm_result_o, 32'd1);
      issue(ALU_SLTU, A_RS1, 1'b0, FWD_IDEX, FWD_IDEX, 32'h8000_0000, 32'd1, 32'd0, 32'd0);
      step(); check("sltu", exm_result_o, 32'd0);
      issue(ALU_SRA, A_RS1, 1'b0, FWD_IDEX, FWD_IDEX, 32'h8000_0000, 32'd4, 32'd0, 32'd0);
      step(); check("sra", exm_result_o, 32'hF800_0000);
      issue(ALU_SRL, A_RS1, 1'b0, FWD_IDEX, FWD_IDEX, 32'h8000_0000, 32'd4, 32'd0, 32'd0);
      step(); check("srl", exm_result_o, 32'h0800_0000);
      issue(ALU_SLL, A_RS1, 1'b0, FWD_IDEX, FWD_IDEX, 32'd1, 32'h21, 32'd0, 32'd0);
      step(); check("sll_shamt5", exm_result_o, 32'd2);
      issue(ALU_LINK, A_RS1, 1'b0, FWD_IDEX, FWD_IDEX, 32'h8000_0000, 32'd1, 32'd0, 32'h100);
      step(); check("link", exm_result_o, 32'h104);
      issue(ALU_ADD, A_RS1, 1'b0, FWD_IDEX, FWD_IDEX, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
      step(); check("add_wrap", exm_result_o, 32'd0);
      issue(ALU_AND, A_RS1, 1'b0, FWD_IDEX, FWD_IDEX, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 32'd0);
      step(); check("and", exm_result_o, 32'h00F0_1200);
      issue(ALU_OR, A_RS1, 1'b0, FWD_IDEX, FWD_IDEX, 32'hF000_0001, 32'h0000_0F00, 32'd0, 32'd0);
      step(); check("or", exm_result_o, 32'hF000_0F01);
      issue(ALU_XOR, A_RS1, 1'b0, FWD_IDEX, FWD_IDEX, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'd0, 32'd0);
      step(); check("xor", exm_result_o, 32'hF0F0_0F0F);
      issue(4'b1010, A_RS1, 1'b0, FWD_IDEX, FWD_IDEX, 32'd9, 32'd9, 32'd0, 32'd0);
      step(); check("undef_op", exm_result_o, 32'd0);

      // Forwarding
      issue(ALU_ADD, A_RS1, 1'b0, FWD_IDEX, FWD_IDEX, 32'd3, 32'd4, 32'd0, 32'd0);
      step(); check("fwd_base", exm_result_o, 32'd7);
      issue(ALU_ADD, A_RS1, 1'b0, FWD_EXM, FWD_EXM, 32'd100, 32'd200, 32'd0, 32'd0);
      step(); check("fwd_exm", exm_result_o, 32'd14);
      check("fwd_exm_store", exm_store_o, 32'd7);
      wb_data_i = 32'd9;
      issue(ALU_ADD, A_RS1, 1'b0, FWD_WB, FWD_WB, 32'd100, 32'd200, 32'd0, 32'd0);
      step(); check("fwd_wb", exm_result_o, 32'd18);
      issue(ALU_ADD, A_RS1, 1'b0, FWD_RSVD, FWD_RSVD, 32'd5, 32'd6, 32'd0, 32'd0);
      step(); check("fwd_rsvd", exm_result_o, 32'd11);

      // Operand selection
      issue(ALU_ADD, A_ZERO, 1'b1, FWD_IDEX, FWD_IDEX, 32'hDEAD, 32'd0, 32'h1234_5000, 32'd0);
      step(); check("lui", exm_result_o, 32'h1234_5000);
      issue(ALU_ADD, A_PC, 1'b1, FWD_IDEX, FWD_IDEX, 32'hDEAD, 32'd0, 32'h1000, 32'h40);
      step(); check("auipc", exm_result_o, 32'h1040);
      issue(ALU_ADD, A_RSVD, 1'b1, FWD_IDEX, FWD_IDEX, 32'hDEAD, 32'd0, 32'h55, 32'h40);
      step(); check("asel_rsvd", exm_result_o, 32'h55);
      wb_data_i = 32'hCAFE_BABE;
      issue(ALU_ADD, A_RS1, 1'b1, FWD_IDEX, FWD_WB, 32'h200, 32'h1111, 32'h10, 32'd0);
      func3_i = 3'd2; reg_write_i = 1'b0; mem_write_i = 1'b1; rd_i = 5'd0;
      step();
      check("sw_result", exm_result_o, 32'h210);
      check("sw_store", exm_store_o, 32'hCAFE_BABE);
      check("sw_memw", 32'(exm_mem_write_o), 32'd1);
      check("sw_func3", 32'(exm_func3_o), 32'd2);
      check("sw_regw", 32'(exm_reg_write_o), 32'd0);

      // Stall with changing inputs
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         issue(ALU_SUB, A_RS1, 1'b0, FWD_IDEX, FWD_IDEX, 32'(i * 17 + 3), 32'd1, 32'd0, 32'd0);
         step();
         check("stall_result", exm_result_o, 32'h210);
         check("stall_store", exm_store_o, 32'hCAFE_BABE);
         check("stall_memw", 32'(exm_mem_write_o), 32'd1);
      end
      flush_i = 1'b1;
      step();
      check("stall_flush_valid", 32'(exm_valid_o), 32'd1);
      check("stall_flush_memw", 32'(exm_mem_write_o), 32'd1);
      check("stall_flush_result", exm_result_o, 32'h210);
      stall_i = 1'b0;
      issue(ALU_ADD, A_RS1, 1'b1, FWD_IDEX, FWD_IDEX, 32'h300, 32'h2222, 32'h4, 32'd0);
      reg_write_i = 1'b0; mem_write_i = 1'b1;
      step();
      check("flush_valid", 32'(exm_valid_o), 32'd0);
      check("flush_memw", 32'(exm_mem_write_o), 32'd0);
      flush_i = 1'b0;

      // Bubble: controls gated by valid
      issue(ALU_ADD, A_RS1, 1'b0, FWD_IDEX, FWD_IDEX, 32'd1, 32'd1, 32'd0, 32'd0);
      id_valid_i = 1'b0; mem_write_i = 1'b1; mem_read_i = 1'b1;
      step();
      check("bubble_valid", 32'(exm_valid_o), 32'd0);
      check("bubble_regw", 32'(exm_reg_write_o), 32'd0);
      check("bubble_memw", 32'(exm_mem_write_o), 32'd0);
      check("bubble_memr", 32'(exm_mem_read_o), 32'd0);

      // x0 destination passes through unchanged
      issue(ALU_ADD, A_RS1, 1'b0, FWD_IDEX, FWD_IDEX, 32'd2, 32'd2, 32'd0, 32'd0);
      rd_i = 5'd0; func3_i = 3'd5;
      step();
      check("x0_rd", 32'(exm_rd_o), 32'd0);
      check("x0_regw", 32'(exm_reg_write_o), 32'd1);
      check("x0_func3", 32'(exm_func3_o), 32'd5);

      // Reset during stall clears state
      stall_i = 1'b1;
      #2 rst = 1'b1;
      #1 check_all_zero("reset_in_stall");
      #1 rst = 1'b0;
      step();
      check("reset_stall_hold", 32'(exm_valid_o), 32'd0);
      stall_i = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32I pipeline, directly downstream of the ALU control decoder.
- Consumes the decoder's 4-bit ALU select plus ID/EX operands, and resolves forwarding for both operands.
- Computes the ALU result and captures it, with control, in the EX/MEM pipeline register; supports stall and flush.
- Also supplies the forwarded rs2 value as store data.

Parameters:
XLEN, 32, datapath width
REGADDR_W, 5, register index width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
stall_i  in  1  hold EX/MEM contents (MEM/WB not ready)
flush_i  in  1  squash instruction entering EX/MEM (branch/jump redirect)
id_valid_i  in  1  ID/EX holds a real instruction
alu_sel_i  in  4  ALU operation from ALU control decoder
a_sel_i  in  2  operand A source: 0 rs1, 1 pc, 2 zero, 3 reserved (treated as zero)
b_imm_i  in  1  operand B source: 1 imm, 0 rs2
fwd_a_i  in  2  rs1 forward: 0 ID/EX value, 1 EX/MEM result, 2 MEM/WB data
fwd_b_i  in  2  rs2 forward, same encoding
rs1_data_i  in  XLEN  rs1 from register file
rs2_data_i  in  XLEN  rs2 from register file
imm_i  in  XLEN  sign-extended immediate (lui: already shifted imm<<12)
pc_i  in  XLEN  instruction PC
wb_data_i  in  XLEN  MEM/WB writeback value for forwarding
rd_i  in  REGADDR_W  destination register
func3_i  in  3  passed through for load/store width
reg_write_i, mem_read_i, mem_write_i  in  1 each  control passthrough
exm_valid_o  out  1  EX/MEM holds a real instruction
exm_result_o  out  XLEN  registered ALU result
exm_store_o  out  XLEN  registered forwarded rs2
exm_rd_o  out  REGADDR_W  registered rd
exm_func3_o  out  3  registered func3
exm_reg_write_o, exm_mem_read_o, exm_mem_write_o  out  1 each  registered control, gated by valid

Behaviour:
- Reset (async, rst=1): every exm_* output is 0 immediately and stays 0 until the first clk edge after release.
- ALU select encoding:
  - 0000 add
  - 0001 sub
  - 0010 and
  - 0011 or
  - 0100 xor
  - 0101 sll
  - 0110 srl
  - 0111 slt (signed)
  - 1000 sltu
  - 1001 sra
  - 1111 link: result = pc_i + 4
  - others: result 0
- Shifts use B[4:0] only. Add/sub wrap modulo 2^XLEN; no overflow flag. slt/sltu produce 0 or 1 zero-extended.
- Forwarding mux is combinational, ahead of the operand-A/B selection:
  - code 1 takes exm_result_o, i.e. the current registered output (back-to-back dependency).
  - code 3 behaves as 0.
- Store data is forwarded rs2, never imm.
- Latency: one cycle, input at edge N, visible on exm_* after edge N.
- Per-edge update priority:
  - stall_i=1: all exm_* hold, flush ignored. Upstream must also hold ID/EX.
  - else flush_i=1: exm_valid_o and the three control outputs become 0; data outputs don't care (implementation holds them).
  - else: all outputs load; exm_valid_o = id_valid_i.
- Control outputs are ANDed with id_valid_i on load, so an invalid bubble never writes registers or memory.
- rd_i=0 with reg_write_i=1 is passed unchanged; writeback ignores x0.
- Reset asserted mid-stall clears state; no instruction replay is required of this block.

Decomposition:
- Package rv32_pkg holds:
  - alu_op_e enum for the 4-bit codes above
  - fwd_sel_e and a_sel_e enums
  - XLEN/REGADDR_W constants
  - exmem_t struct for the pipeline register contents
- Sub-module rv32_alu: purely combinational, (op, a, b, pc) -> result, reusable in the testbench scoreboard.
- ex_stage contains the forwarding muxes, operand selection and the exmem_t register.

Test Plan:
1. Reset: rst=1 mid-traffic -> all exm_* 0 without a clock edge; first post-reset edge with add 5+7 -> exm_result_o=12, valid=1.
2. ALU sweep (rs1=0x8000_0000, rs2=1): sub -> 0x7FFF_FFFF, slt -> 1, sltu -> 0, sra by 4 of 0x8000_0000 -> 0xF800_0000, srl -> 0x0800_0000, link with pc=0x100 -> 0x104.
3. Forwarding, back-to-back dependency: add x1=3+4, then add x2=x1+x1 with fwd_a=fwd_b=1 -> 14. Same with fwd=2 and wb_data_i=9 -> 18.
4. Operand selection: lui with a_sel=2, imm=0x12345000 -> 0x12345000. auipc with a_sel=1, pc=0x40, imm=0x1000 -> 0x1040. sw with fwd_b=2 -> exm_store_o=wb_data_i, result = rs1+imm.
5. Stall/flush: stall_i=1 for 3 cycles with changing inputs -> outputs frozen. stall+flush together -> hold. flush alone on sw -> exm_mem_write_o=0, exm_valid_o=0.
6. Bubble: id_valid_i=0 with reg_write_i=1 and mem_write_i=1 -> exm_reg_write_o=0, exm_mem_write_o=0, exm_valid_o=0.
